// File: rtl/tinker_pkg.sv
// Shared definitions for the Tinker decode stage: opcode map, ALU encoding,
// decode-control struct and the opcode-to-control lookup.
package tinker_pkg;

  localparam logic [4:0] OP_AND       = 5'h00;
  localparam logic [4:0] OP_OR        = 5'h01;
  localparam logic [4:0] OP_XOR       = 5'h02;
  localparam logic [4:0] OP_NOT       = 5'h03;
  localparam logic [4:0] OP_SHFTR     = 5'h04;
  localparam logic [4:0] OP_SHFTRI    = 5'h05;
  localparam logic [4:0] OP_SHFTL     = 5'h06;
  localparam logic [4:0] OP_SHFTLI    = 5'h07;
  localparam logic [4:0] OP_BR        = 5'h08;
  localparam logic [4:0] OP_BRR       = 5'h09;
  localparam logic [4:0] OP_BRRL      = 5'h0a;
  localparam logic [4:0] OP_BRNZ      = 5'h0b;
  localparam logic [4:0] OP_CALL      = 5'h0c;
  localparam logic [4:0] OP_RETURN    = 5'h0d;
  localparam logic [4:0] OP_BRGT      = 5'h0e;
  localparam logic [4:0] OP_PRIV      = 5'h0f;
  localparam logic [4:0] OP_MOV_LOAD  = 5'h10;
  localparam logic [4:0] OP_MOV_REG   = 5'h11;
  localparam logic [4:0] OP_MOV_LIT   = 5'h12;
  localparam logic [4:0] OP_MOV_STORE = 5'h13;
  localparam logic [4:0] OP_ADDF      = 5'h14;
  localparam logic [4:0] OP_SUBF      = 5'h15;
  localparam logic [4:0] OP_MULF      = 5'h16;
  localparam logic [4:0] OP_DIVF      = 5'h17;
  localparam logic [4:0] OP_ADD       = 5'h18;
  localparam logic [4:0] OP_ADDI      = 5'h19;
  localparam logic [4:0] OP_SUB       = 5'h1a;
  localparam logic [4:0] OP_SUBI      = 5'h1b;
  localparam logic [4:0] OP_MUL       = 5'h1c;
  localparam logic [4:0] OP_DIV       = 5'h1d;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_MUL    = 4'd2,
    ALU_DIV    = 4'd3,
    ALU_AND    = 4'd4,
    ALU_OR     = 4'd5,
    ALU_XOR    = 4'd6,
    ALU_NOT    = 4'd7,
    ALU_SHR    = 4'd8,
    ALU_SHL    = 4'd9,
    ALU_PASS   = 4'd10,
    ALU_BRANCH = 4'd11
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    is_immediate;
    logic    reg_write_enable;
    logic    is_float;
    logic    illegal;
  } decode_ctrl_t;

  typedef struct packed {
    logic [4:0]   opcode;
    logic [4:0]   rd;
    logic [4:0]   rs;
    logic [4:0]   rt;
    logic [11:0]  literal;
    decode_ctrl_t ctrl;
  } decode_out_t;

  // Control bits for an opcode; unmapped opcodes come back flagged illegal.
  function automatic decode_ctrl_t decode_opcode(input logic [4:0] opcode);
    decode_ctrl_t c;
    c.alu_op           = ALU_ADD;
    c.is_immediate     = 1'b0;
    c.reg_write_enable = 1'b1;
    c.is_float         = 1'b0;
    c.illegal          = 1'b0;
    case (opcode)
      OP_AND:       c.alu_op = ALU_AND;
      OP_OR:        c.alu_op = ALU_OR;
      OP_XOR:       c.alu_op = ALU_XOR;
      OP_NOT:       c.alu_op = ALU_NOT;
      OP_SHFTR:     c.alu_op = ALU_SHR;
      OP_SHFTRI:    begin c.alu_op = ALU_SHR; c.is_immediate = 1'b1; end
      OP_SHFTL:     c.alu_op = ALU_SHL;
      OP_SHFTLI:    begin c.alu_op = ALU_SHL; c.is_immediate = 1'b1; end
      OP_BR, OP_BRR, OP_BRNZ, OP_CALL, OP_RETURN, OP_BRGT: begin
        c.alu_op = ALU_BRANCH; c.reg_write_enable = 1'b0;
      end
      OP_BRRL:      begin c.alu_op = ALU_BRANCH; c.reg_write_enable = 1'b0; c.is_immediate = 1'b1; end
      OP_PRIV:      begin c.alu_op = ALU_PASS; c.reg_write_enable = 1'b0; c.is_immediate = 1'b1; end
      OP_MOV_LOAD:  c.is_immediate = 1'b1;
      OP_MOV_REG:   c.alu_op = ALU_PASS;
      OP_MOV_LIT:   begin c.alu_op = ALU_PASS; c.is_immediate = 1'b1; end
      OP_MOV_STORE: begin c.is_immediate = 1'b1; c.reg_write_enable = 1'b0; end
      OP_ADDF:      c.is_float = 1'b1;
      OP_SUBF:      begin c.alu_op = ALU_SUB; c.is_float = 1'b1; end
      OP_MULF:      begin c.alu_op = ALU_MUL; c.is_float = 1'b1; end
      OP_DIVF:      begin c.alu_op = ALU_DIV; c.is_float = 1'b1; end
      OP_ADD:       c.alu_op = ALU_ADD;
      OP_ADDI:      c.is_immediate = 1'b1;
      OP_SUB:       c.alu_op = ALU_SUB;
      OP_SUBI:      begin c.alu_op = ALU_SUB; c.is_immediate = 1'b1; end
      OP_MUL:       c.alu_op = ALU_MUL;
      OP_DIV:       c.alu_op = ALU_DIV;
      default:      begin c.illegal = 1'b1; c.reg_write_enable = 1'b0; end
    endcase
    return c;
  endfunction

  // True when a register index names an architectural register.
  function automatic logic reg_in_range(input logic [4:0] idx, input int num_regs);
    return int'(idx) < num_regs;
  endfunction

endpackage

// File: rtl/tinker_decode_if.sv
// Fetch, execute and writeback signals of the decode stage.
// master = the environment around the stage, slave = the stage itself.
interface tinker_decode_if #(
  parameter int ERR_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [4:0]       out_opcode;
  logic [4:0]       out_rd;
  logic [4:0]       out_rs;
  logic [4:0]       out_rt;
  logic [11:0]      out_literal;
  logic [3:0]       out_alu_op;
  logic             out_is_immediate;
  logic             out_reg_write_enable;
  logic             out_is_float;
  logic             out_illegal;
  logic             wb_valid;
  logic [4:0]       wb_rd;
  logic [ERR_W-1:0] err_count;

  modport master (
    output in_valid, in_instr, flush, out_ready, wb_valid, wb_rd,
    input  in_ready, out_valid, out_opcode, out_rd, out_rs, out_rt, out_literal,
           out_alu_op, out_is_immediate, out_reg_write_enable, out_is_float,
           out_illegal, err_count
  );

  modport slave (
    input  in_valid, in_instr, flush, out_ready, wb_valid, wb_rd,
    output in_ready, out_valid, out_opcode, out_rd, out_rs, out_rt, out_literal,
           out_alu_op, out_is_immediate, out_reg_write_enable, out_is_float,
           out_illegal, err_count
  );
endinterface

// File: rtl/tinker_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// writer issues to execute, cleared when writeback retires it.
module tinker_scoreboard #(
  parameter int NUM_REGS = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_en,
  input  logic [4:0] set_idx,
  input  logic       clr_en,
  input  logic [4:0] clr_idx,
  input  logic [4:0] query_a,
  input  logic [4:0] query_b,
  input  logic [4:0] query_c,
  output logic       hit_a,
  output logic       hit_b,
  output logic       hit_c
);
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_next;

  // Indices outside the tracked range match no bit, so they read as clear.
  function automatic logic lookup(input logic [NUM_REGS-1:0] v, input logic [4:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (idx == 5'(i)) r = v[i];
    return r;
  endfunction

  // Next-state: clear first, then set, so a same-cycle set wins.
  always_comb begin
    // NOTE: a full default before any conditional write keeps this block free of latches.
    pending_next = pending;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (clr_en && clr_idx == 5'(i)) pending_next[i] = 1'b0;
      if (set_en && set_idx == 5'(i)) pending_next[i] = 1'b1;
    end
  end

  // Pending-bit register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) pending <= '0;
    else       pending <= pending_next;
  end

  assign hit_a = lookup(pending, query_a);
  assign hit_b = lookup(pending, query_b);
  assign hit_c = lookup(pending, query_c);
endmodule

// File: rtl/tinker_decode_stage.sv
// Tinker instruction-decode stage: combinational decode, RAW/WAW hazard
// stall against a pending-write scoreboard, valid/ready output register
// and a saturating illegal-instruction counter.
module tinker_decode_stage
  import tinker_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ERR_W    = 16
) (
  input logic            clk,
  input logic            reset,
  tinker_decode_if.slave bus
);
  logic [4:0]       opcode, rd, rs, rt;
  logic [11:0]      literal;
  decode_ctrl_t     ctrl;
  decode_out_t      out_q;
  logic             out_valid_q;
  logic [ERR_W-1:0] err_q;
  logic             held_write;
  logic             sb_rs, sb_rt, sb_rd;
  logic             hit_rs, hit_rt, hit_rd;
  logic             hazard, accept, out_fire;

  assign {opcode, rd, rs, rt, literal} = bus.in_instr;

  // Decode; out-of-range registers make the instruction illegal and illegal never writes.
  always_comb begin
    ctrl = decode_opcode(opcode);
    if (!reg_in_range(rd, NUM_REGS) || !reg_in_range(rs, NUM_REGS) ||
        (!ctrl.is_immediate && !reg_in_range(rt, NUM_REGS)))
      ctrl.illegal = 1'b1;
    if (ctrl.illegal) ctrl.reg_write_enable = 1'b0;
  end

  // A register is pending if the scoreboard says so or the held instruction is about to write it.
  assign held_write = out_valid_q && out_q.ctrl.reg_write_enable;
  assign hit_rs     = sb_rs || (held_write && out_q.rd == rs);
  assign hit_rt     = sb_rt || (held_write && out_q.rd == rt);
  assign hit_rd     = sb_rd || (held_write && out_q.rd == rd);
  assign hazard     = !ctrl.illegal &&
                      (hit_rs || (!ctrl.is_immediate && hit_rt) ||
                       (ctrl.reg_write_enable && hit_rd));

  assign bus.in_ready = !bus.flush && (!out_valid_q || bus.out_ready) && !hazard;
  assign accept       = bus.in_valid && bus.in_ready;
  assign out_fire     = out_valid_q && bus.out_ready;

  tinker_scoreboard #(.NUM_REGS(NUM_REGS)) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .set_en  (out_fire && out_q.ctrl.reg_write_enable),
    .set_idx (out_q.rd),
    .clr_en  (bus.wb_valid),
    .clr_idx (bus.wb_rd),
    .query_a (rs),
    .query_b (rt),
    .query_c (rd),
    .hit_a   (sb_rs),
    .hit_b   (sb_rt),
    .hit_c   (sb_rd)
  );

  // Output register: load on accept, drop valid on consume or flush, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the payload is reset along with valid so out_* read as zero straight after reset.
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_q       <= '{opcode: opcode, rd: rd, rs: rs, rt: rt, literal: literal, ctrl: ctrl};
      out_valid_q <= 1'b1;
    end else if (bus.flush || bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Saturating count of accepted illegal instructions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      err_q <= '0;
    else if (accept && ctrl.illegal && err_q != {ERR_W{1'b1}})
      err_q <= err_q + 1'b1;
  end

  assign bus.out_valid            = out_valid_q;
  assign bus.out_opcode           = out_q.opcode;
  assign bus.out_rd               = out_q.rd;
  assign bus.out_rs               = out_q.rs;
  assign bus.out_rt               = out_q.rt;
  assign bus.out_literal          = out_q.literal;
  assign bus.out_alu_op           = out_q.ctrl.alu_op;
  assign bus.out_is_immediate     = out_q.ctrl.is_immediate;
  assign bus.out_reg_write_enable = out_q.ctrl.reg_write_enable;
  assign bus.out_is_float         = out_q.ctrl.is_float;
  assign bus.out_illegal          = out_q.ctrl.illegal;
  assign bus.err_count            = err_q;
endmodule

// File: tb/tb_tinker_decode_stage.sv
// Directed bench for tinker_decode_stage. A second instance with a 2-bit
// error counter shares the stimulus to exercise counter saturation.
module tb_tinker_decode_stage;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  tinker_decode_if #(.ERR_W(16)) bus ();
  tinker_decode_if #(.ERR_W(2))  bus2 ();

  tinker_decode_stage #(.NUM_REGS(32), .ERR_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  tinker_decode_stage #(.NUM_REGS(32), .ERR_W(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  assign bus2.in_valid  = bus.in_valid;
  assign bus2.in_instr  = bus.in_instr;
  assign bus2.flush     = bus.flush;
  assign bus2.out_ready = bus.out_ready;
  assign bus2.wb_valid  = bus.wb_valid;
  assign bus2.wb_rd     = bus.wb_rd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr);
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    #1;
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [11:0] lit);
    return {op, rd, rs, rt, lit};
  endfunction

  function automatic logic [31:0] pend();
    return dut.u_scoreboard.pending;
  endfunction

  task automatic retire(input logic [4:0] r);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = r;
    step();
    bus.wb_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_instr   = 32'h0;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b1;
    bus.wb_valid   = 1'b0;
    bus.wb_rd      = 5'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_err", bus.err_count, 0);
    check("rst_pending", pend(), 0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);

    // ADD R1,R2,R3 decode and scoreboard set
    drive(32'hC0443000);
    check("add_in_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    check("add_valid", bus.out_valid, 1);
    check("add_opcode", bus.out_opcode, 32'h18);
    check("add_rd", bus.out_rd, 1);
    check("add_rs", bus.out_rs, 2);
    check("add_rt", bus.out_rt, 3);
    check("add_alu", bus.out_alu_op, 0);
    check("add_we", bus.out_reg_write_enable, 1);
    check("add_imm", bus.out_is_immediate, 0);
    check("add_illegal", bus.out_illegal, 0);
    step();
    check("add_sb_set", pend(), 32'h2);
    check("add_consumed", bus.out_valid, 0);
    retire(5'd1);
    check("add_sb_clr", pend(), 0);

    // RAW: ADD R1,R2,R3 then ADD R4,R1,R5
    drive(32'hC0443000);
    step();
    drive(enc(5'h18, 5'd4, 5'd1, 5'd5, 12'h0));
    check("raw_held", bus.in_ready, 0);
    step();
    check("raw_out_drop", bus.out_valid, 0);
    check("raw_pending", bus.in_ready, 0);
    step();
    check("raw_pending2", bus.in_ready, 0);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd1;
    #1;
    check("raw_wb_cycle", bus.in_ready, 0);
    step();
    bus.wb_valid = 1'b0;
    #1;
    check("raw_release", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    check("raw_accept", bus.out_valid, 1);
    check("raw_rd", bus.out_rd, 4);
    check("raw_rs", bus.out_rs, 1);
    step();
    check("raw_sb", pend(), 32'h10);

    // ADDI R1,R2,0x3F with a pending R4 in the rt field
    drive(enc(5'h19, 5'd1, 5'd2, 5'd4, 12'h03F));
    check("addi_no_rt_stall", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    check("addi_literal", bus.out_literal, 32'h03F);
    check("addi_imm", bus.out_is_immediate, 1);
    check("addi_we", bus.out_reg_write_enable, 1);
    check("addi_alu", bus.out_alu_op, 0);
    check("addi_rt", bus.out_rt, 4);
    step();
    check("addi_sb", pend(), 32'h12);
    drive(enc(5'h18, 5'd6, 5'd7, 5'd4, 12'h0));
    check("rt_stall", bus.in_ready, 0);
    drive(enc(5'h18, 5'd4, 5'd0, 5'd0, 12'h0));
    check("waw_stall", bus.in_ready, 0);

    // ADDF R8,R9,R10, with writeback of R8 on the same edge as its set
    drive(enc(5'h14, 5'd8, 5'd9, 5'd10, 12'h0));
    check("addf_in_ready", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    check("addf_opcode", bus.out_opcode, 32'h14);
    check("addf_float", bus.out_is_float, 1);
    check("addf_we", bus.out_reg_write_enable, 1);
    check("addf_alu", bus.out_alu_op, 0);
    retire(5'd8);
    check("set_wins", pend(), 32'h112);
    retire(5'd1);
    retire(5'd4);
    retire(5'd8);
    check("sb_cleared", pend(), 0);

    // Illegal opcodes: never stall, never write, counted
    drive(32'hC0443000);
    step();
    drive(enc(5'h1f, 5'd1, 5'd1, 5'd1, 12'h0));
    check("illegal_no_stall", bus.in_ready, 1);
    step();
    check("illegal_flag", bus.out_illegal, 1);
    check("illegal_we", bus.out_reg_write_enable, 0);
    check("illegal_opcode", bus.out_opcode, 32'h1f);
    check("illegal_err1", bus.err_count, 1);
    step();
    step();
    bus.in_valid = 1'b0;
    check("illegal_err3", bus.err_count, 3);
    check("illegal_err3_sat", bus2.err_count, 3);
    step();
    check("illegal_no_sb", pend(), 32'h2);
    drive(enc(5'h1e, 5'd0, 5'd0, 5'd0, 12'h0));
    step();
    step();
    bus.in_valid = 1'b0;
    check("illegal_err5", bus.err_count, 5);
    check("illegal_saturate", bus2.err_count, 3);
    retire(5'd1);
    check("illegal_sb_clr", pend(), 0);

    // Backpressure: out_ready low for 4 cycles, then flush
    bus.out_ready = 1'b0;
    drive(enc(5'h18, 5'd2, 5'd3, 5'd4, 12'h0));
    step();
    drive(enc(5'h14, 5'd8, 5'd9, 5'd10, 12'h0));
    for (int i = 0; i < 4; i++) begin
      check("stall_valid", bus.out_valid, 1);
      check("stall_rd", bus.out_rd, 2);
      check("stall_in_ready", bus.in_ready, 0);
      step();
    end
    bus.flush = 1'b1;
    #1;
    check("flush_in_ready", bus.in_ready, 0);
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_drop", bus.out_valid, 0);
    check("flush_sb", pend(), 0);
    check("flush_err", bus.err_count, 5);

    // Flush together with out_ready consumes the held writer
    bus.out_ready = 1'b1;
    drive(enc(5'h18, 5'd3, 5'd0, 5'd0, 12'h0));
    step();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_consume_valid", bus.out_valid, 0);
    check("flush_consume_sb", pend(), 32'h8);

    // Back-to-back independent instructions
    drive(enc(5'h18, 5'd5, 5'd6, 5'd7, 12'h0));
    step();
    drive(enc(5'h18, 5'd9, 5'd10, 5'd11, 12'h0));
    check("throughput", bus.in_ready, 1);
    step();
    bus.in_valid = 1'b0;
    check("throughput_rd", bus.out_rd, 9);
    check("throughput_sb", pend(), 32'h28);

    // Asynchronous reset mid-cycle with live state
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", bus.out_valid, 0);
    check("async_rd", bus.out_rd, 0);
    check("async_opcode", bus.out_opcode, 0);
    check("async_we", bus.out_reg_write_enable, 0);
    check("async_sb", pend(), 0);
    check("async_err", bus.err_count, 0);
    check("async_err_sat", bus2.err_count, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
